// File: rtl/demultiplexer_1_to_2_stream_if.sv
// rtl/demultiplexer_1_to_2_stream_if.sv - valid/ready beat stream with a per-beat destination select
interface demultiplexer_1_to_2_stream_if #(
    parameter int BUS_WIDTH = 32
);
    logic [BUS_WIDTH-1:0] data;
    logic                 select;
    logic                 valid;
    logic                 ready;

    modport master (
        output data,
        output select,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  select,
        input  valid,
        output ready
    );
endinterface

// File: rtl/demultiplexer_1_to_2_stream.sv
// rtl/demultiplexer_1_to_2_stream.sv - routes one stream to two outputs through independent 2-entry FIFOs
module demultiplexer_1_to_2_stream #(
    parameter int BUS_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    demultiplexer_1_to_2_stream_if.slave  in_s,
    demultiplexer_1_to_2_stream_if.master out1,
    demultiplexer_1_to_2_stream_if.master out2
);
    logic [1:0]           count  [2];
    logic                 rd_ptr [2];
    logic                 wr_ptr [2];
    logic [BUS_WIDTH-1:0] mem    [2][2];

    logic       accept;
    logic [1:0] push;
    logic [1:0] pop;

    // Readiness looks only at the registered fill level, so a full FIFO refuses
    // a beat even if it is being popped on the same edge.
    assign in_s.ready = (in_s.select ? count[1] : count[0]) < 2'd2;
    assign accept     = in_s.valid & in_s.ready;
    assign push[0]    = accept & ~in_s.select;
    assign push[1]    = accept &  in_s.select;
    assign pop[0]     = (count[0] != 2'd0) & out1.ready;
    assign pop[1]     = (count[1] != 2'd0) & out2.ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < 2; n++) begin
                count[n]  <= 2'd0;
                rd_ptr[n] <= 1'b0;
                wr_ptr[n] <= 1'b0;
                mem[n][0] <= '0;
                mem[n][1] <= '0;
            end
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (push[n]) begin
                    mem[n][wr_ptr[n]] <= in_s.data;
                    wr_ptr[n]         <= ~wr_ptr[n];
                end
                if (pop[n]) begin
                    rd_ptr[n] <= ~rd_ptr[n];
                end
                count[n] <= count[n] + {1'b0, push[n]} - {1'b0, pop[n]};
            end
        end
    end

    // The select field on each output just tags which destination it is.
    assign out1.data   = mem[0][rd_ptr[0]];
    assign out1.valid  = (count[0] != 2'd0);
    assign out1.select = 1'b0;

    assign out2.data   = mem[1][rd_ptr[1]];
    assign out2.valid  = (count[1] != 2'd0);
    assign out2.select = 1'b1;
endmodule

// File: tb/tb_demultiplexer_1_to_2_stream.sv
// tb/tb_demultiplexer_1_to_2_stream.sv - randomized and directed bench with a queue-based reference model
module tb_demultiplexer_1_to_2_stream;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    demultiplexer_1_to_2_stream_if #(.BUS_WIDTH(W)) in_if ();
    demultiplexer_1_to_2_stream_if #(.BUS_WIDTH(W)) o1_if ();
    demultiplexer_1_to_2_stream_if #(.BUS_WIDTH(W)) o2_if ();

    demultiplexer_1_to_2_stream #(.BUS_WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .in_s (in_if),
        .out1 (o1_if),
        .out2 (o2_if)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: each destination is a FIFO of at most two words. Readiness is
    // decided from the fill level before the edge; pops and pushes then apply.
    logic [W-1:0] q1[$];
    logic [W-1:0] q2[$];

    always @(negedge clk) begin
        bit exp_rdy;
        bit p1, p2, acc;
        if (rst) begin
            q1.delete();
            q2.delete();
        end else begin
            exp_rdy = in_if.select ? (q2.size() < 2) : (q1.size() < 2);
            chk("m_out1_valid", 64'(o1_if.valid), 64'(q1.size() > 0));
            if (q1.size() > 0) chk("m_out1_data", 64'(o1_if.data), 64'(q1[0]));
            chk("m_out2_valid", 64'(o2_if.valid), 64'(q2.size() > 0));
            if (q2.size() > 0) chk("m_out2_data", 64'(o2_if.data), 64'(q2[0]));
            if (in_if.valid) chk("m_in_ready", 64'(in_if.ready), 64'(exp_rdy));
            p1  = (q1.size() > 0) && o1_if.ready;
            p2  = (q2.size() > 0) && o2_if.ready;
            acc = in_if.valid && exp_rdy;
            if (p1) void'(q1.pop_front());
            if (p2) void'(q2.pop_front());
            if (acc) begin
                if (in_if.select) q2.push_back(in_if.data);
                else              q1.push_back(in_if.data);
            end
        end
    end

    task automatic drive(input bit v, input bit s, input logic [W-1:0] d, input bit r1, input bit r2);
        in_if.valid  = v;
        in_if.select = s;
        in_if.data   = d;
        o1_if.ready  = r1;
        o2_if.ready  = r2;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(0, 0, '0, 0, 0);
        #2;
        chk("reset_out1_valid", 64'(o1_if.valid), 64'd0);
        chk("reset_out2_valid", 64'(o2_if.valid), 64'd0);
        chk("reset_out1_data",  64'(o1_if.data),  64'd0);
        chk("reset_out2_data",  64'(o2_if.data),  64'd0);
        step();
        step();
        rst = 1'b0;
        step();

        // Routing and one-cycle latency
        drive(1, 0, 32'hA5A5A5A5, 1, 1);
        step();
        chk("lat_out1_valid", 64'(o1_if.valid), 64'd1);
        chk("lat_out1_data",  64'(o1_if.data),  64'hA5A5A5A5);
        chk("lat_out2_idle",  64'(o2_if.valid), 64'd0);
        drive(1, 1, 32'h5A5A5A5A, 1, 1);
        step();
        chk("lat_out2_valid", 64'(o2_if.valid), 64'd1);
        chk("lat_out2_data",  64'(o2_if.data),  64'h5A5A5A5A);
        chk("lat_out1_idle",  64'(o1_if.valid), 64'd0);
        drive(0, 0, '0, 1, 1);
        step();

        // Backpressure on OUT1, isolation for OUT2
        drive(1, 0, 32'd1, 0, 1);
        step();
        drive(1, 0, 32'd2, 0, 1);
        step();
        drive(1, 0, 32'd3, 0, 1);
        #1;
        chk("full_in_ready", 64'(in_if.ready), 64'd0);
        step();
        drive(1, 1, 32'h77, 0, 1);
        #1;
        chk("iso_in_ready", 64'(in_if.ready), 64'd1);
        step();
        chk("iso_out2_data",  64'(o2_if.data),  64'h77);
        chk("iso_out2_valid", 64'(o2_if.valid), 64'd1);
        chk("hold_out1_data", 64'(o1_if.data),  64'd1);

        // Drain: beat 3 accepted only once FIFO 1 drops below two entries
        drive(1, 0, 32'd3, 1, 1);
        #1;
        chk("drain_not_ready", 64'(in_if.ready), 64'd0);
        step();
        chk("drain_head2", 64'(o1_if.data), 64'd2);
        #1;
        chk("drain_ready", 64'(in_if.ready), 64'd1);
        step();
        chk("drain_head3", 64'(o1_if.data), 64'd3);
        drive(0, 0, '0, 1, 1);
        step();
        chk("drain_empty", 64'(o1_if.valid), 64'd0);

        // Push and pop together at count 1
        drive(1, 0, 32'h11, 0, 1);
        step();
        drive(1, 0, 32'h22, 1, 1);
        step();
        chk("pp_valid", 64'(o1_if.valid), 64'd1);
        chk("pp_head",  64'(o1_if.data),  64'h22);
        drive(0, 0, '0, 1, 1);
        step();
        chk("pp_empty", 64'(o1_if.valid), 64'd0);

        // Streaming at full rate
        for (int i = 0; i < 16; i++) begin
            drive(1, 1'($urandom_range(0, 1)), $urandom, 1, 1);
            #1;
            chk("stream_ready", 64'(in_if.ready), 64'd1);
            step();
        end

        // Random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), $urandom,
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)));
            step();
        end

        // Asynchronous reset with both FIFOs full
        drive(1, 0, 32'hDEAD0001, 0, 0);
        step();
        drive(1, 0, 32'hDEAD0002, 0, 0);
        step();
        drive(1, 1, 32'hBEEF0001, 0, 0);
        step();
        drive(1, 1, 32'hBEEF0002, 0, 0);
        step();
        drive(0, 0, '0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out1_valid", 64'(o1_if.valid), 64'd0);
        chk("arst_out2_valid", 64'(o2_if.valid), 64'd0);
        chk("arst_out1_data",  64'(o1_if.data),  64'd0);
        chk("arst_out2_data",  64'(o2_if.data),  64'd0);
        step();
        rst = 1'b0;
        step();
        in_if.select = 1'b0;
        #1;
        chk("post_rst_ready0", 64'(in_if.ready), 64'd1);
        in_if.select = 1'b1;
        #1;
        chk("post_rst_ready1", 64'(in_if.ready), 64'd1);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
